// File: rtl/sudoku_pkg.sv
// Shared types for the Sudoku game controller: one-hot state encoding and width helper.
package sudoku_pkg;

  typedef enum logic [4:0] {
    S_LOAD      = 5'b00001,
    S_SOLVE     = 5'b00010,
    S_CHECK     = 5'b00100,
    S_CORRECT   = 5'b01000,
    S_INCORRECT = 5'b10000
  } state_t;

  // Index width that never collapses to zero bits for tiny grids.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sudoku_cursor.sv
// Cursor row/col registers with R > L > U > D priority; edges clamp unless CURSOR_WRAP_EN is defined.
module sudoku_cursor
  import sudoku_pkg::*;
#(
  parameter int N  = 9,
  parameter int IW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          home,
  input  logic          en,
  input  logic          R,
  input  logic          L,
  input  logic          U,
  input  logic          D,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [IW-1:0] row_nx, col_nx;

  always_comb begin
    row_nx = row;
    col_nx = col;
    if (home) begin
      row_nx = '0;
      col_nx = '0;
    end else if (en) begin
      if (R) begin
        if (col != LAST) col_nx = col + 1'b1;
        else if (WRAP)   col_nx = '0;
      end else if (L) begin
        if (col != '0)   col_nx = col - 1'b1;
        else if (WRAP)   col_nx = LAST;
      end else if (U) begin
        if (row != '0)   row_nx = row - 1'b1;
        else if (WRAP)   row_nx = LAST;
      end else if (D) begin
        if (row != LAST) row_nx = row + 1'b1;
        else if (WRAP)   row_nx = '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nx;
      col <= col_nx;
    end
  end

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: host load, player entry with given-cell protection, one-cell-per-cycle check.
// Optional CURSOR_WRAP_EN makes cursor moves wrap at grid edges (handled in sudoku_cursor).
//   LOAD      | host writes puzzle/solution cells
//   SOLVE     | player moves cursor and commits values
//   CHECK     | row-major scan counting mismatches, N*N cycles
//   CORRECT   | no mismatches; Ack returns to LOAD
//   INCORRECT | mismatches found; Ack resumes SOLVE
module sudoku_game_ctrl
  import sudoku_pkg::*;
#(
  parameter  int BOX_R = 3,
  parameter  int BOX_C = 3,
  localparam int N     = BOX_R * BOX_C,
  localparam int VW    = $clog2(N + 1),
  localparam int IW    = clog2_min1(N),
  localparam int EW    = $clog2(N * N + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_row,
  input  logic [IW-1:0] ld_col,
  input  logic [VW-1:0] ld_val,
  input  logic [VW-1:0] ld_sol,
  input  logic          ld_done,
  input  logic          R,
  input  logic          L,
  input  logic          U,
  input  logic          D,
  input  logic          C,
  input  logic [VW-1:0] userIn,
  input  logic          CheckSolu,
  input  logic          Ack,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic [VW-1:0] cur_val,
  output logic          cur_given,
  output logic [EW-1:0] err_cnt,
  output logic          q_Load,
  output logic          q_Solve,
  output logic          q_Check,
  output logic          q_Correct,
  output logic          q_Incorrect
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [VW-1:0] N_V      = VW'(N);

  state_t        state, state_nx;
  logic [VW-1:0] puzzle [N][N];
  logic [VW-1:0] sol    [N][N];
  logic          given  [N][N];
  logic [IW-1:0] scan_r, scan_c;
  logic [EW-1:0] err_sum;
  logic          ld_in_range, do_check, do_commit, any_move, scan_last, mism;

  assign ld_in_range = (ld_row <= LAST_IDX) && (ld_col <= LAST_IDX);
  assign do_check    = (state == S_SOLVE) && CheckSolu;
  assign any_move    = R | L | U | D;
  assign do_commit   = (state == S_SOLVE) && !CheckSolu && !any_move && C &&
                       !given[row][col] && (userIn <= N_V);
  assign scan_last   = (scan_r == LAST_IDX) && (scan_c == LAST_IDX);
  assign mism        = (puzzle[scan_r][scan_c] == '0) ||
                       (puzzle[scan_r][scan_c] != sol[scan_r][scan_c]);
  assign err_sum     = err_cnt + EW'(mism);
  assign cur_val     = puzzle[row][col];
  assign cur_given   = given[row][col];

  sudoku_cursor #(.N(N), .IW(IW)) u_cursor (
    .Clk   (Clk),
    .Reset (Reset),
    .home  ((state == S_LOAD) && ld_done),
    .en    ((state == S_SOLVE) && !CheckSolu),
    .R     (R),
    .L     (L),
    .U     (U),
    .D     (D),
    .row   (row),
    .col   (col)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    q_Load      = 1'b0;
    q_Solve     = 1'b0;
    q_Check     = 1'b0;
    q_Correct   = 1'b0;
    q_Incorrect = 1'b0;
    case (state)
      S_LOAD: begin
        q_Load = 1'b1;
        if (ld_done) state_nx = S_SOLVE;
      end
      S_SOLVE: begin
        q_Solve = 1'b1;
        if (CheckSolu) state_nx = S_CHECK;
      end
      S_CHECK: begin
        q_Check = 1'b1;
        // The last cell's compare is folded into the verdict.
        if (scan_last) state_nx = (err_sum == '0) ? S_CORRECT : S_INCORRECT;
      end
      S_CORRECT: begin
        q_Correct = 1'b1;
        if (Ack) state_nx = S_LOAD;
      end
      S_INCORRECT: begin
        q_Incorrect = 1'b1;
        if (Ack) state_nx = S_SOLVE;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scan_r  <= '0;
      scan_c  <= '0;
      err_cnt <= '0;
    end else if (do_check) begin
      scan_r  <= '0;
      scan_c  <= '0;
      err_cnt <= '0;
    end else if (state == S_CHECK) begin
      err_cnt <= err_sum;
      if (scan_last) begin
        scan_r <= '0;
        scan_c <= '0;
      end else if (scan_c == LAST_IDX) begin
        scan_c <= '0;
        scan_r <= scan_r + 1'b1;
      end else begin
        scan_c <= scan_c + 1'b1;
      end
    end
  end

  // Grid storage is deliberately unreset; the host reloads after any reset.
  always_ff @(posedge Clk) begin
    if ((state == S_LOAD) && ld_valid && ld_in_range) begin
      puzzle[ld_row][ld_col] <= ld_val;
      sol[ld_row][ld_col]    <= ld_sol;
      given[ld_row][ld_col]  <= (ld_val != '0);
    end else if (do_commit) begin
      puzzle[row][col] <= userIn;
    end
  end

endmodule
